mdu_sequencer: RTL and testbench

Multi-cycle multiply/divide sequencer that owns the HI/LO registers in the EX stage of the pipelined MIPS core. It accepts decoded MDU commands (start, move-to, move-from with a 3-bit select), runs multiplies in 5 cycles and divides in 10, and commits HI/LO atomically at completion. It reports `busy` to the hazard unit, which stalls any MDU instruction in D while an operation is in flight. It honours an exception/interrupt `cancel` so that a flushed instruction never changes HI/LO.

---
 rtl/mdu_sequencer_pkg.sv | 23 ++
 rtl/mdu_arith.sv | 70 +++++++
 rtl/mdu_sequencer.sv | 155 +++++++++++++++
 tb/tb_mdu_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_sequencer_pkg.sv
// mdu_sequencer_pkg: shared MDU constants (command/select codes, cycle
// counts) and the sequencer state encoding.
package mdu_sequencer_pkg;

  // Default busy lengths for multiply and divide.
  localparam int MDU_MUL_CYCLES = 5;
  localparam int MDU_DIV_CYCLES = 10;

  // MDUSel codes: 0..3 are arithmetic ops, 4/5 select HI/LO for moves.
  localparam logic [2:0] MULDIV_DO_MUL    = 3'd0;
  localparam logic [2:0] MULDIV_DO_MULU   = 3'd1;
  localparam logic [2:0] MULDIV_DO_DIV    = 3'd2;
  localparam logic [2:0] MULDIV_DO_DIVU   = 3'd3;
  localparam logic [2:0] MULDIV_SELECT_HI = 3'd4;
  localparam logic [2:0] MULDIV_SELECT_LO = 3'd5;

  // Sequencer state encoding.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_t;

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: purely combinational multiply/divide datapath.
// op (low two bits of MULDIV_DO_*), a, b -> {hi_res, lo_res}.
// Divide by zero yields LO=all ones, HI=dividend.
module mdu_arith
  import mdu_sequencer_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res
);

  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] q_u;
  logic [31:0] r_u;
  logic [31:0] q_s;
  logic [31:0] r_s;

  // Compute every result in parallel, then pick by op. Signed divide works
  // on magnitudes so INT_MIN/-1 wraps cleanly to INT_MIN with remainder 0.
  always_comb begin
    a_neg  = a[31];
    b_neg  = b[31];
    a_mag  = a_neg ? (~a + 32'd1) : a;
    b_mag  = b_neg ? (~b + 32'd1) : b;
    prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prod_u = {32'd0, a} * {32'd0, b};
    q_mag  = 32'd0;
    r_mag  = 32'd0;
    q_u    = 32'd0;
    r_u    = 32'd0;
    if (b != 32'd0) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
      q_u   = a / b;
      r_u   = a % b;
    end
    q_s    = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    r_s    = a_neg ? (~r_mag + 32'd1) : r_mag;
    hi_res = 32'd0;
    lo_res = 32'd0;
    case ({1'b0, op})
      MULDIV_DO_MUL: begin
        hi_res = prod_s[63:32];
        lo_res = prod_s[31:0];
      end
      MULDIV_DO_MULU: begin
        hi_res = prod_u[63:32];
        lo_res = prod_u[31:0];
      end
      MULDIV_DO_DIV: begin
        hi_res = (b == 32'd0) ? a : r_s;
        lo_res = (b == 32'd0) ? 32'hFFFF_FFFF : q_s;
      end
      default: begin
        hi_res = (b == 32'd0) ? a : r_u;
        lo_res = (b == 32'd0) ? 32'hFFFF_FFFF : q_u;
      end
    endcase
  end

endmodule

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multi-cycle mult/div sequencer owning HI/LO in EX.
// The result is computed at acceptance, parked in a pending register and
// committed to HI/LO atomically when the busy countdown expires.
// Optional build macro: MDU_DIVZERO_HOLD_EN (divide by zero completes in
// one cycle and leaves HI/LO unchanged).
module mdu_sequencer
  import mdu_sequencer_pkg::*;
#(
  parameter int MUL_CYCLES = MDU_MUL_CYCLES,
  parameter int DIV_CYCLES = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        move_to,
  input  logic [2:0]  sel,
  input  logic        cancel,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] rdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output mdu_state_t  state_dbg
);

  localparam int CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // Command acceptance: a command is taken on the rising edge where it is
  // presented with cancel=0 and busy=0; nothing is queued, so anything
  // presented while busy is dropped. start wins over move_to; start needs
  // sel in 0..3, move_to needs SELECT_HI/SELECT_LO, other sels are no-ops.

  mdu_state_t       state_q;
  mdu_state_t       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_load;
  logic [31:0]      pend_hi_q;
  logic [31:0]      pend_lo_q;
  logic             pend_commit_q;
  logic             pend_commit_d;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic [31:0]      arith_hi;
  logic [31:0]      arith_lo;
  logic             is_div;
  logic             accept_start;
  logic             accept_move;
  logic             done;
`ifdef MDU_DIVZERO_HOLD_EN
  logic             div_zero;
  assign div_zero = (rt_val == 32'd0);
`endif

  assign busy         = (state_q == ST_RUN);
  assign is_div       = sel[1];
  assign accept_start = start & ~cancel & ~busy & ~sel[2];
  assign accept_move  = move_to & ~start & ~cancel & ~busy &
                        ((sel == MULDIV_SELECT_HI) | (sel == MULDIV_SELECT_LO));

  mdu_arith u_arith (
    .op     (sel[1:0]),
    .a      (rs_val),
    .b      (rt_val),
    .hi_res (arith_hi),
    .lo_res (arith_lo)
  );

  // Pick the countdown length and whether the pending result will commit.
  always_comb begin
    cnt_load      = CNT_W'(MUL_CYCLES);
    pend_commit_d = 1'b1;
    if (is_div) begin
      cnt_load = CNT_W'(DIV_CYCLES);
    end
`ifdef MDU_DIVZERO_HOLD_EN
    if (is_div && div_zero) begin
      cnt_load      = CNT_W'(1);
      pend_commit_d = 1'b0;
    end
`endif
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and completion strobe.
  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_start) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Countdown and pending result; loaded on acceptance, counts in RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q         <= '0;
      pend_hi_q     <= 32'd0;
      pend_lo_q     <= 32'd0;
      pend_commit_q <= 1'b0;
    end else if (accept_start) begin
      cnt_q         <= cnt_load;
      pend_hi_q     <= arith_hi;
      pend_lo_q     <= arith_lo;
      pend_commit_q <= pend_commit_d;
    end else if (state_q == ST_RUN) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Architectural HI/LO: atomic commit at completion, or a move.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else if (done) begin
      if (pend_commit_q) begin
        hi_q <= pend_hi_q;
        lo_q <= pend_lo_q;
      end
    end else if (accept_move) begin
      if (sel == MULDIV_SELECT_HI) begin
        hi_q <= rs_val;
      end else begin
        lo_q <= rs_val;
      end
    end
  end

  assign hi        = hi_q;
  assign lo        = lo_q;
  assign rdata     = (sel == MULDIV_SELECT_HI) ? hi_q : lo_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: scoreboard bench for mdu_sequencer. Directed cases from
// the test plan plus randomized ops checked against an arithmetic model.
module tb_mdu_sequencer;
  import mdu_sequencer_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        move_to;
  logic [2:0]  sel;
  logic        cancel;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic [31:0] rdata;
  logic [31:0] hi;
  logic [31:0] lo;
  mdu_state_t  state_dbg;

  always #5 clk = ~clk;

  mdu_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .move_to   (move_to),
    .sel       (sel),
    .cancel    (cancel),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .busy      (busy),
    .rdata     (rdata),
    .hi        (hi),
    .lo        (lo),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [71:0] exp_q[$];   // {busy_len[7:0], hi[31:0], lo[31:0]}
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  int          run_len = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: result of one op from plain 64-bit arithmetic.
  function automatic logic [71:0] model_op(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    longint      sa, sb, p, q, r;
    logic [63:0] u;
    logic [31:0] rh, rl;
    logic [7:0]  len;
    len = op[1] ? 8'(MDU_DIV_CYCLES) : 8'(MDU_MUL_CYCLES);
    rh  = 32'd0;
    rl  = 32'd0;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    if (op == 2'd0) begin
      p  = sa * sb;
      rh = p[63:32];
      rl = p[31:0];
    end else if (op == 2'd1) begin
      u  = {32'd0, a} * {32'd0, b};
      rh = u[63:32];
      rl = u[31:0];
    end else if (b == 32'd0) begin
`ifdef MDU_DIVZERO_HOLD_EN
      len = 8'd1;
      rh  = m_hi;
      rl  = m_lo;
`else
      rh  = a;
      rl  = 32'hFFFF_FFFF;
`endif
    end else if (op == 2'd2) begin
      q  = sa / sb;
      r  = sa % sb;
      rh = r[31:0];
      rl = q[31:0];
    end else begin
      rh = a % b;
      rl = a / b;
    end
    return {len, rh, rl};
  endfunction

  // ---------------- monitor ----------------
  // Measures each busy window and checks HI/LO on the cycle busy drops.
  always @(negedge clk) begin
    logic [71:0] e;
    if (reset) begin
      run_len = 0;
    end else if (busy) begin
      run_len++;
    end else if (run_len != 0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL commit_unexpected: got hi=%h lo=%h expected no commit", hi, lo);
      end else begin
        e = exp_q.pop_front();
        check("commit_len", 64'(run_len), 64'(e[71:64]));
        check("commit_hilo", {hi, lo}, e[63:0]);
      end
      run_len = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_op(input logic [2:0] op_sel, input logic [31:0] a, input logic [31:0] b,
                       input bit noise);
    logic [71:0] e;
    int          n;
    e = model_op(op_sel[1:0], a, b);
    n = int'(e[71:64]);
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b1; move_to = 1'b0; cancel = 1'b0;
    sel = op_sel; rs_val = a; rt_val = b;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    check("state_run", 64'(state_dbg), 64'(ST_RUN));
    check("hilo_hidden_during_run", {hi, lo}, {m_hi, m_lo});
    for (int i = 0; i < n; i++) begin
      if (noise) begin
        start   = 1'($urandom_range(0, 1));
        move_to = 1'($urandom_range(0, 1));
        cancel  = 1'($urandom_range(0, 1));
        sel     = 3'($urandom_range(0, 5));
        rs_val  = $urandom;
        rt_val  = $urandom;
      end
      @(negedge clk);
    end
    start = 1'b0; move_to = 1'b0; cancel = 1'b0;
    m_hi = e[63:32];
    m_lo = e[31:0];
    check("busy_after_done", 64'(busy), 64'd0);
    sel = MULDIV_SELECT_HI;
    #1 check("rdata_hi", 64'(rdata), 64'(m_hi));
    sel = MULDIV_SELECT_LO;
    #1 check("rdata_lo", 64'(rdata), 64'(m_lo));
  endtask

  task automatic do_move(input logic [2:0] msel, input logic [31:0] val, input logic canc);
    @(negedge clk);
    move_to = 1'b1; start = 1'b0; cancel = canc; sel = msel; rs_val = val;
    @(negedge clk);
    move_to = 1'b0; cancel = 1'b0;
    if (!canc && msel == MULDIV_SELECT_HI) m_hi = val;
    if (!canc && msel == MULDIV_SELECT_LO) m_lo = val;
    check("move_busy", 64'(busy), 64'd0);
    check("move_hilo", {hi, lo}, {m_hi, m_lo});
  endtask

  // A start that must be dropped (cancelled or invalid select).
  task automatic do_dropped_start(input logic [2:0] ssel, input logic canc);
    @(negedge clk);
    start = 1'b1; cancel = canc; sel = ssel; rs_val = $urandom; rt_val = $urandom;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    check("dropped_start_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("dropped_start_hilo", {hi, lo}, {m_hi, m_lo});
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [2:0]  r_op;
    logic [31:0] ra, rb;
    reset = 1'b1; start = 1'b0; move_to = 1'b0; cancel = 1'b0;
    sel = MULDIV_SELECT_LO; rs_val = 32'd0; rt_val = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    check("reset_state", 64'(state_dbg), 64'(ST_IDLE));
    #3 reset = 1'b0;
    @(negedge clk);
    check("reset_rdata", 64'(rdata), 64'd0);

    // Directed cases.
    do_op(MULDIV_DO_MUL,  32'hFFFF_FFFD, 32'd4, 1'b0);    // -3*4
    do_op(MULDIV_DO_DIVU, 32'd100, 32'd7, 1'b0);
    do_op(MULDIV_DO_DIV,  32'hFFFF_FFF9, 32'd2, 1'b0);    // -7/2
    do_move(MULDIV_SELECT_HI, 32'h0000_1234, 1'b0);
    do_move(MULDIV_SELECT_HI, 32'h0000_5678, 1'b1);
    do_move(MULDIV_SELECT_LO, 32'hCAFE_F00D, 1'b0);
    do_dropped_start(MULDIV_DO_MUL, 1'b1);
    do_dropped_start(3'd7, 1'b0);
    do_dropped_start(3'd6, 1'b0);
    do_op(MULDIV_DO_MUL,  32'd12345, 32'd678, 1'b1);      // noise while busy
    do_op(MULDIV_DO_DIVU, 32'hDEAD_BEEF, 32'd0, 1'b0);    // divide by zero
    do_op(MULDIV_DO_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

    // Randomized ops and moves.
    for (int k = 0; k < 40; k++) begin
      r_op = 3'($urandom_range(0, 3));
      ra   = $urandom;
      rb   = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'($urandom_range(0, 200)); rb = 32'($urandom_range(1, 9)); end
        2: rb = -32'($urandom_range(1, 9));
        default: ;
      endcase
      if ($urandom_range(0, 4) == 0) begin
        do_move(($urandom_range(0, 1) == 1) ? MULDIV_SELECT_HI : MULDIV_SELECT_LO, ra,
                1'($urandom_range(0, 1)));
      end else begin
        do_op(r_op, ra, rb, 1'($urandom_range(0, 1)));
      end
    end

    // Reset in the middle of a divide.
    do_op(MULDIV_DO_MUL, 32'hFFFF_FFFD, 32'd4, 1'b0);
    @(negedge clk);
    start = 1'b1; sel = MULDIV_DO_DIV; rs_val = 32'd1000; rt_val = 32'd3;
    @(negedge clk);
    start = 1'b0; sel = MULDIV_SELECT_LO;
    repeat (2) @(negedge clk);
    #3 reset = 1'b1;
    #1;
    m_hi = 32'd0;
    m_lo = 32'd0;
    check("reset_mid_busy", 64'(busy), 64'd0);
    check("reset_mid_hilo", {hi, lo}, 64'd0);
    check("reset_mid_rdata", 64'(rdata), 64'd0);
    @(negedge clk);
    #3 reset = 1'b0;
    repeat (12) @(negedge clk);
    check("post_reset_busy", 64'(busy), 64'd0);
    check("post_reset_mflo", 64'(rdata), 64'd0);
    check("post_reset_hilo", {hi, lo}, 64'd0);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
